seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Consumer end of the 4-digit BCD display bus (`num[15:0]`, digit 1 = `num[15:12]` leftmost, digit 4 = `num[3:0]` rightmost).
- Time-multiplexes the four digits onto the board's shared `seg`/`anode` pins.
- Blinks the digit currently selected for editing (`which_seg_on`, one-hot).
- Sits between the service modules' `num` output and the top-level 7-segment pins, replacing the unused `anode` path.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit; must be >= 2.
- BLINK_DIV, 25000000: clk cycles per blink half-period; must be >= 2.
- ACTIVE_LOW, 1: 1 = `seg` and `anode` are active-low (common-anode board); 0 = active-high.

Ports:
- clk, input, 1: single system clock; every flop is on its rising edge.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: 1 = scan and display; 0 = display dark.
- num, input, 16: four BCD digits, [15:12] leftmost.
- blink_sel, input, 4: one-hot edit position. Bit 3 = leftmost, bit 0 = rightmost; 0000 = no blink.
- dp_mask, input, 4: decimal point enable per digit, same bit order as `blink_sel`.
- seg, output, 8: [6:0] = gfedcba, [7] = dp; registered.
- anode, output, 4: one-hot digit enable, bit 3 = leftmost; registered.
- frame_tick, output, 1: one-cycle pulse when a new frame starts (leftmost digit loaded).

Behaviour:
- Reset (sampled on a clk edge while reset = 1):
  - refresh_cnt = 0, digit_idx = 3 (leftmost), blink_cnt = 0, blink_phase = 0, shadow_num = 16'h0000.
  - frame_tick = 0.
  - seg and anode are all-off: 8'hFF / 4'hF when ACTIVE_LOW = 1; 8'h00 / 4'h0 when ACTIVE_LOW = 0.
  - Reset overrides `enable` and every other input in the same cycle.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap cycle (cnt == REFRESH_DIV-1), digit_idx steps 3 -> 2 -> 1 -> 0 -> 3.
- Frame capture:
  - When digit_idx steps 0 -> 3, shadow_num <= num and frame_tick = 1 for that cycle.
  - All four digits of a frame therefore come from one coherent `num` sample; changes to `num` mid-frame appear in the next frame.
  - shadow_num also loads once on the first cycle after reset is released, so there is no all-zero first frame.
- Blink counter:
  - Free-running 0..BLINK_DIV-1; blink_phase toggles on each wrap.
  - Runs regardless of `blink_sel`.
- Output latency:
  - `seg`/`anode` are registered from the current digit_idx, shadow_num, blink_phase, `blink_sel` and `dp_mask`.
  - `anode` changes exactly 1 cycle after digit_idx changes.
  - Exactly one anode bit is active whenever enable = 1 and reset is not asserted.
- Digit decode (active-high gfedcba, before polarity):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - Values 10..15 decode to 0000000 (blank).
- Blanking: when blink_phase = 1 and `blink_sel[digit_idx]` = 1, seg[6:0] are all off. The anode stays driven and dp follows `dp_mask`.
- `blink_sel` with more than one bit set: every selected digit blinks. No error is flagged.
- dp: seg[7] is on iff `dp_mask[digit_idx]` = 1.
- ACTIVE_LOW = 1: `seg` and `anode` are the bitwise inverse of the active-high values.
- enable = 0:
  - refresh_cnt, digit_idx and blink counters hold their values.
  - `seg` and `anode` go to the all-off value on the next cycle; frame_tick = 0.
  - On re-enable, scanning resumes from the held digit_idx.
- Reset mid-frame: the next cycle is all-off and the scan restarts at the leftmost digit. No partially lit digit survives.

Test Plan (REFRESH_DIV = 4, BLINK_DIV = 16, ACTIVE_LOW = 1):
- Reset
  - Stimulus: reset high 3 cycles, enable = 1, num = 16'h1234.
  - Required: seg = 8'hFF, anode = 4'hF during reset.
  - Required after release: anode sequence 0111, 1011, 1101, 1110, 4 cycles each. seg[6:0] = ~0000110, ~1011011, ~1001111, ~1100110 respectively.
- Tear-free update
  - Stimulus: change num 16'h1234 -> 16'h5678 while anode = 1011.
  - Required: remaining digits of the frame still show 3 and 4. The next frame starts with frame_tick = 1 and shows 5, 6, 7, 8.
- Blink
  - Stimulus: blink_sel = 4'b0100, num = 16'h0959.
  - Required: while anode = 1011, seg[6:0] alternates between ~1101111 and 7'h7F every 16 cycles. Other digits never blank.
- Invalid BCD and dp
  - Stimulus: num = 16'hA000, dp_mask = 4'b1000.
  - Required: leftmost digit seg = 8'h7F (dp on, segments blank). Other digits seg = {1'b1, ~0111111}.
- Enable gating
  - Stimulus: enable = 0 for 10 cycles while anode = 1101.
  - Required: anode = 4'hF and seg = 8'hFF within 1 cycle. On enable = 1, anode resumes at 1101 for the remaining count.
- Reset mid-operation
  - Stimulus: assert reset for 1 cycle while anode = 1110.
  - Required: next cycle all-off. Then anode = 0111 with frame_tick pulsing once at restart.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver: scans a BCD word onto shared seg/anode pins,
// latching the word once per frame so digits never tear, and blinks the selected digit.
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] num,
  input  logic [3:0]  blink_sel,
  input  logic [3:0]  dp_mask,
  output logic [7:0]  seg,
  output logic [3:0]  anode,
  output logic        frame_tick
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  localparam logic [7:0] SEG_OFF   = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0] ANODE_OFF = ACTIVE_LOW ? 4'hF : 4'h0;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [15:0]   shadow_num;
  logic          load_pending;

  logic          refresh_wrap;
  logic          blink_wrap;
  logic          frame_start;
  logic [15:0]   cur_num;
  logic [3:0]    cur_digit;
  logic          blank_now;
  logic [7:0]    seg_ah;
  logic [3:0]    anode_ah;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign blink_wrap   = (blink_cnt == BW'(BLINK_DIV - 1));
  assign frame_start  = enable && refresh_wrap && (digit_idx == 2'd0);

  // The first cycle after reset displays num directly, so the opening frame is not all zeros.
  assign cur_num   = load_pending ? num : shadow_num;
  assign cur_digit = cur_num[{digit_idx, 2'b00} +: 4];
  assign blank_now = blink_phase && blink_sel[digit_idx];
  assign seg_ah    = {dp_mask[digit_idx], blank_now ? 7'b0000000 : bcd_to_seg(cur_digit)};
  assign anode_ah  = 4'b0001 << digit_idx;

  // NOTE: every register here uses non-blocking assignment so all flops update from
  // pre-edge values; blocking assignment would let later statements see new values.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt  <= '0;
      digit_idx    <= 2'd3;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      shadow_num   <= 16'h0000;
      load_pending <= 1'b1;
      frame_tick   <= 1'b0;
      seg          <= SEG_OFF;
      anode        <= ANODE_OFF;
    end else begin
      load_pending <= 1'b0;
      frame_tick   <= enable && (load_pending || (refresh_wrap && digit_idx == 2'd0));
      if (load_pending || frame_start)
        shadow_num <= num;

      if (enable) begin
        refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
        if (refresh_wrap)
          digit_idx <= digit_idx - 2'd1;
        blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
        if (blink_wrap)
          blink_phase <= ~blink_phase;
        seg   <= seg_ah ^ {8{ACTIVE_LOW}};
        anode <= anode_ah ^ {4{ACTIVE_LOW}};
      end else begin
        seg   <= SEG_OFF;
        anode <= ANODE_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4, BLINK_DIV=16, active-low pins.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] num = 16'h1234;
  logic [3:0]  blink_sel = 4'b0000;
  logic [3:0]  dp_mask = 4'b0000;
  logic [7:0]  seg;
  logic [3:0]  anode;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(
    .REFRESH_DIV(4),
    .BLINK_DIV  (16),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .num       (num),
    .blink_sel (blink_sel),
    .dp_mask   (dp_mask),
    .seg       (seg),
    .anode     (anode),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check("rst_anode", 16'(anode), 16'hF);
      check("rst_seg", 16'(seg), 16'hFF);
      check("rst_tick", 16'(frame_tick), 16'h0);
    end
    reset = 1'b0;
  endtask

  task automatic show(input string tag, input logic [3:0] an, input logic [7:0] sg,
                      input int n, input logic [15:0] ft_mask);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_anode"}, 16'(anode), 16'(an));
      check({tag, "_seg"}, 16'(seg), 16'(sg));
      check({tag, "_tick"}, 16'(frame_tick), 16'(ft_mask[i]));
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] s1, input logic [7:0] s2,
                       input logic [7:0] s3, input logic [7:0] s4, input bit ft_first);
    show({tag, "_d1"}, 4'b0111, s1, 4, ft_first ? 16'h1 : 16'h0);
    show({tag, "_d2"}, 4'b1011, s2, 4, 16'h0);
    show({tag, "_d3"}, 4'b1101, s3, 4, 16'h0);
    show({tag, "_d4"}, 4'b1110, s4, 4, 16'h8);
  endtask

  initial begin
    // Reset, first frame from 1234, then a mid-frame change to 5678.
    num = 16'h1234;
    do_reset(3);
    show("r_d1", 4'b0111, 8'hF9, 4, 16'h1);
    show("r_d2", 4'b1011, 8'hA4, 1, 16'h0);
    num = 16'h5678;
    show("t_d2", 4'b1011, 8'hA4, 3, 16'h0);
    show("t_d3", 4'b1101, 8'hB0, 4, 16'h0);
    show("t_d4", 4'b1110, 8'h99, 4, 16'h8);
    frame("new", 8'h92, 8'h82, 8'hF8, 8'h80, 1'b0);

    // Blink on digit 2: blanked every other frame, others untouched.
    num = 16'h0959;
    blink_sel = 4'b0100;
    do_reset(1);
    frame("bk0", 8'hC0, 8'h90, 8'h92, 8'h90, 1'b1);
    frame("bk1", 8'hC0, 8'hFF, 8'h92, 8'h90, 1'b0);
    frame("bk2", 8'hC0, 8'h90, 8'h92, 8'h90, 1'b0);

    // Invalid BCD with decimal point on the leftmost digit.
    num = 16'hA000;
    blink_sel = 4'b0000;
    dp_mask = 4'b1000;
    do_reset(1);
    frame("bcd", 8'h7F, 8'hC0, 8'hC0, 8'hC0, 1'b1);

    // Enable gating during the third digit.
    show("en_d1", 4'b0111, 8'h7F, 4, 16'h0);
    show("en_d2", 4'b1011, 8'hC0, 4, 16'h0);
    show("en_d3a", 4'b1101, 8'hC0, 2, 16'h0);
    enable = 1'b0;
    show("en_off", 4'hF, 8'hFF, 10, 16'h0);
    enable = 1'b1;
    show("en_d3b", 4'b1101, 8'hC0, 2, 16'h0);
    show("en_d4", 4'b1110, 8'hC0, 4, 16'h8);

    // Reset mid-frame while the rightmost digit is lit.
    show("mr_d1", 4'b0111, 8'h7F, 4, 16'h0);
    show("mr_d2", 4'b1011, 8'hC0, 4, 16'h0);
    show("mr_d3", 4'b1101, 8'hC0, 4, 16'h0);
    show("mr_d4", 4'b1110, 8'hC0, 2, 16'h0);
    do_reset(1);
    show("mr_re1", 4'b0111, 8'h7F, 4, 16'h1);
    show("mr_re2", 4'b1011, 8'hC0, 1, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
